// File: rtl/line_buffer.sv
// line_buffer: keeps the previous WIN_SIZE-1 image rows in per-row circular
// memories and emits a column-aligned vertical slice for every accepted pixel
// (current pixel on pixel_out, rows above it on line_out), one cycle later.
//
// Optional feature macro: LINE_BUFFER_ZERO_FILL_EN
//   defined   -> line_out[k] reads as zero until row k+1 of the current frame
//                has been stored (zero padding at the top border).
//   undefined -> line_out[k] is the raw row memory; lines_ready is the only
//                indication that the rows above belong to the current frame.
module line_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int IMAGE_WIDTH = 10,
  parameter int WIN_SIZE    = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 pixel_valid,
  input  logic [DATA_WIDTH-1:0]                pixel_in,
  input  logic                                 sof,
  output logic [DATA_WIDTH-1:0]                pixel_out,
  output logic [WIN_SIZE-2:0][DATA_WIDTH-1:0]  line_out,
  output logic                                 out_valid,
  output logic [$clog2(IMAGE_WIDTH)-1:0]       out_col,
  output logic                                 eol_out,
  output logic                                 lines_ready
);

  localparam int COL_W  = $clog2(IMAGE_WIDTH);
  localparam int FILL_W = $clog2(WIN_SIZE);
  localparam int ROWS   = WIN_SIZE - 1;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIN_SIZE - 1);

  // Row memories, indexed by column; deliberately not reset.
  logic [DATA_WIDTH-1:0] mem_q [ROWS][IMAGE_WIDTH];

  // Counters
  logic [COL_W-1:0]  col_q, col_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  // Registered outputs
  logic [DATA_WIDTH-1:0]           pixel_out_q;
  logic [ROWS-1:0][DATA_WIDTH-1:0] line_out_q;
  logic                            out_valid_q;
  logic [COL_W-1:0]                out_col_q;
  logic                            eol_q;
  logic                            lines_ready_q;

  // Effective column / fill for the pixel on the inputs (sof restarts both)
  logic [COL_W-1:0]                c_s;
  logic [FILL_W-1:0]               f_s;
  logic                            last_s;
  logic [ROWS-1:0][DATA_WIDTH-1:0] line_rd_s;

  // Effective position, next counter values and the slice read from memory.
  always_comb begin
    c_s    = sof ? '0 : col_q;
    f_s    = sof ? '0 : fill_q;
    last_s = (c_s == COL_LAST);
    col_d  = last_s ? '0 : (c_s + COL_W'(1));
    if (last_s) begin
      fill_d = (f_s == FILL_MAX) ? f_s : (f_s + FILL_W'(1));
    end else begin
      fill_d = f_s;
    end
    line_rd_s = '0;
    for (int k = 0; k < ROWS; k++) begin
`ifdef LINE_BUFFER_ZERO_FILL_EN
      // Row k+1 above is only valid once more than k rows are complete.
      line_rd_s[k] = (f_s <= FILL_W'(k)) ? '0 : mem_q[k][c_s];
`else
      line_rd_s[k] = mem_q[k][c_s];
`endif
    end
  end

  // Row memory update: newest row in mem[0], older rows shift down one slot.
  // Reads above use the pre-edge contents, so line_out never shows pixel_in.
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      mem_q[0][c_s] <= pixel_in;
      for (int k = 1; k < ROWS; k++) begin
        mem_q[k][c_s] <= mem_q[k-1][c_s];
      end
    end
  end

  // Counters and registered outputs; outputs hold during input gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q         <= '0;
      fill_q        <= '0;
      pixel_out_q   <= '0;
      line_out_q    <= '0;
      out_valid_q   <= 1'b0;
      out_col_q     <= '0;
      eol_q         <= 1'b0;
      lines_ready_q <= 1'b0;
    end else if (pixel_valid) begin
      col_q         <= col_d;
      fill_q        <= fill_d;
      pixel_out_q   <= pixel_in;
      line_out_q    <= line_rd_s;
      out_valid_q   <= 1'b1;
      out_col_q     <= c_s;
      eol_q         <= last_s;
      lines_ready_q <= (f_s == FILL_MAX);
    end else begin
      out_valid_q   <= 1'b0;
    end
  end

  assign pixel_out   = pixel_out_q;
  assign line_out    = line_out_q;
  assign out_valid   = out_valid_q;
  assign out_col     = out_col_q;
  assign eol_out     = eol_q;
  assign lines_ready = lines_ready_q;

endmodule

// File: tb/tb_line_buffer.sv
// Directed bench for line_buffer (IMAGE_WIDTH=10, WIN_SIZE=3, pixel = r*10+c).
// Expected values are hand-derived from the row-memory behaviour; a -1
// expectation means the memory slot holds uninitialised data and is skipped.
module tb_line_buffer;

  localparam int DW = 8;
  localparam int IW = 10;
  localparam int WS = 3;
`ifdef LINE_BUFFER_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   pixel_valid = 1'b0;
  logic [DW-1:0]          pixel_in = '0;
  logic                   sof = 1'b0;
  logic [DW-1:0]          pixel_out;
  logic [WS-2:0][DW-1:0]  line_out;
  logic                   out_valid;
  logic [$clog2(IW)-1:0]  out_col;
  logic                   eol_out;
  logic                   lines_ready;

  int checks = 0;
  int failures = 0;

  line_buffer #(.DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .WIN_SIZE(WS)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_valid(pixel_valid), .pixel_in(pixel_in),
    .sof(sof), .pixel_out(pixel_out), .line_out(line_out),
    .out_valid(out_valid), .out_col(out_col), .eol_out(eol_out),
    .lines_ready(lines_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Value seen on a row output when that row is not yet filled this frame.
  function automatic int zf(input int raw);
    return ZF ? 0 : raw;
  endfunction

  // Drive one cycle of input at the falling edge; return just after the capture edge.
  task automatic send(input logic v, input logic s, input int p);
    @(negedge clk);
    pixel_valid = v;
    sof         = s;
    pixel_in    = DW'(p);
    @(posedge clk);
    #1;
  endtask

  // Accept one pixel and check every output against the expected values.
  task automatic pix(input logic s, input int p, input int col, input logic lr,
                     input int l0, input int l1);
    send(1'b1, s, p);
    check("pixel_out", 32'(pixel_out), 32'(p));
    check("out_valid", 32'(out_valid), 32'd1);
    check("out_col", 32'(out_col), 32'(col));
    check("eol_out", 32'(eol_out), (col == IW - 1) ? 32'd1 : 32'd0);
    check("lines_ready", 32'(lines_ready), 32'(lr));
    if (l0 >= 0) check("line_out0", 32'(line_out[0]), 32'(l0));
    if (l1 >= 0) check("line_out1", 32'(line_out[1]), 32'(l1));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_pixel_out"}, 32'(pixel_out), 32'd0);
    check({tag, "_line_out"}, 32'(line_out), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_col"}, 32'(out_col), 32'd0);
    check({tag, "_eol_out"}, 32'(eol_out), 32'd0);
    check({tag, "_lines_ready"}, 32'(lines_ready), 32'd0);
  endtask

  initial begin
    int p;
    // Reset held for 5 cycles
    repeat (5) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous stream: 5 rows, sof on first pixel; memories start uninitialised
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < IW; c++) begin
        p = r * 10 + c;
        pix(r == 0 && c == 0, p, c, r >= 2,
            (r >= 1) ? p - 10 : zf(-1),
            (r >= 2) ? p - 20 : zf(-1));
      end
    end

    // Gapped frame of 3 rows; rows 4/3 of the previous frame are stale
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < IW; c++) begin
        p = r * 10 + c;
        if (r == 0)      pix(c == 0, p, c, 1'b0, zf(40 + c), zf(30 + c));
        else if (r == 1) pix(1'b0, p, c, 1'b0, c, zf(40 + c));
        else             pix(1'b0, p, c, 1'b1, 10 + c, c);
        send(1'b0, 1'b0, 8'hAA);
        check("gap_out_valid", 32'(out_valid), 32'd0);
        check("gap_pixel_out", 32'(pixel_out), 32'(p));
        check("gap_out_col", 32'(out_col), 32'(c));
      end
    end

    // Second frame after a 3-row frame: row 0 sees 20+c / 10+c (or zeros)
    for (int c = 0; c < IW; c++) pix(c == 0, c, c, 1'b0, zf(20 + c), zf(10 + c));
    for (int c = 0; c < IW; c++) pix(1'b0, 10 + c, c, 1'b0, c, zf(20 + c));
    for (int c = 0; c < 5; c++)  pix(1'b0, 20 + c, c, 1'b1, 10 + c, c);

    // Frame restart mid-row at row 2, col 5 with pixel 99
    pix(1'b1, 99, 0, 1'b0, zf(20), zf(10));
    for (int c = 1; c < IW; c++)
      pix(1'b0, c, c, 1'b0, zf((c <= 4) ? 20 + c : 10 + c), zf((c <= 4) ? 10 + c : c));
    for (int c = 0; c < IW; c++)
      pix(1'b0, 10 + c, c, 1'b0, (c == 0) ? 99 : c,
          zf((c == 0) ? 20 : ((c <= 4) ? 20 + c : 10 + c)));
    pix(1'b0, 20, 0, 1'b1, 10, 99);

    // sof on the cycle that would be end-of-row
    for (int c = 1; c < IW - 1; c++) pix(1'b0, 20 + c, c, 1'b1, 10 + c, c);
    pix(1'b1, 77, 0, 1'b0, zf(20), zf(10));
    pix(1'b0, 5, 1, 1'b0, zf(21), zf(11));

    // Asynchronous reset mid-row: outputs clear without a clock edge
    #2;
    pixel_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_cleared("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    // First pixel after reset is col 0, fill 0, even without sof
    pix(1'b0, 42, 0, 1'b0, zf(77), zf(20));
    pix(1'b0, 43, 1, 1'b0, zf(5), zf(21));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
